// File: rtl/photocell_pkg.sv
// -----------------------------------------------------------------------------
// photocell_pkg
//
// Shared definitions for the photocell front-end.
//   mode_e      : per-channel edge select (OFF / RISE / FALL / BOTH).
//                 Bit 0 enables beam-restored events, bit 1 enables
//                 beam-broken events.
//   IDLE_LEVEL  : line level of an unobstructed beam. Used as the reset value
//                 of the synchroniser and the debounced level.
// -----------------------------------------------------------------------------
package photocell_pkg;

   typedef enum logic [1:0] {
      MODE_OFF  = 2'b00,
      MODE_RISE = 2'b01,
      MODE_FALL = 2'b10,
      MODE_BOTH = 2'b11
   } mode_e;

   localparam logic IDLE_LEVEL = 1'b1;

endpackage : photocell_pkg

// File: rtl/photocell_if.sv
// -----------------------------------------------------------------------------
// photocell_if
//
// Bundle of the per-channel photocell buses.
//   in    : raw photocell levels, 1 = beam intact, 0 = beam broken
//   mode  : per-channel edge select, channel i at bits [2i+1:2i]
//   pulse : one-cycle event strobe per channel
//   level : debounced line level per channel
//   stuck : beam held broken for the stuck threshold
//
// Modports:
//   master : the side driving the pins and mode (board / bench)
//   slave  : the photocell_array front-end
// -----------------------------------------------------------------------------
interface photocell_if #(
   parameter int N_CH = 2
);

   logic [N_CH-1:0]   in;
   logic [2*N_CH-1:0] mode;
   logic [N_CH-1:0]   pulse;
   logic [N_CH-1:0]   level;
   logic [N_CH-1:0]   stuck;

   modport master (
      output in,
      output mode,
      input  pulse,
      input  level,
      input  stuck
   );

   modport slave (
      input  in,
      input  mode,
      output pulse,
      output level,
      output stuck
   );

endinterface : photocell_if

// File: rtl/photocell_channel.sv
// -----------------------------------------------------------------------------
// photocell_channel
//
// One photocell channel: synchroniser, debounce, edge/mode event logic and
// stuck-beam detection.
//
// Ports:
//   clk      in  : clock, all state on rising edge
//   rst      in  : asynchronous active-high reset
//   in_i     in  : raw photocell level (1 = beam intact)
//   mode_i   in  : edge select, see photocell_pkg::mode_e
//   pulse_o  out : one-cycle strobe after an accepted transition that
//                  matches mode_i
//   level_o  out : debounced level
//   stuck_o  out : beam broken for STUCK_CYC consecutive cycles
// -----------------------------------------------------------------------------
module photocell_channel
   import photocell_pkg::*;
#(
   parameter int SYNC_STAGES  = 2,
   parameter int DEBOUNCE_CYC = 4,
   parameter int STUCK_CYC    = 1024
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_i,
   input  logic [1:0] mode_i,
   output logic       pulse_o,
   output logic       level_o,
   output logic       stuck_o
);

   localparam int DCNT_W = $clog2(DEBOUNCE_CYC + 1);
   localparam int SCNT_W = (STUCK_CYC > 0) ? $clog2(STUCK_CYC + 1) : 1;

   localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYC - 1);
   localparam logic [SCNT_W-1:0] SCNT_SAT  = SCNT_W'(STUCK_CYC);
   localparam logic              STUCK_EN  = (STUCK_CYC > 0);

   logic [SYNC_STAGES-1:0] sync_q,  sync_d;
   logic [DCNT_W-1:0]      dcnt_q,  dcnt_d;
   logic [SCNT_W-1:0]      scnt_q,  scnt_d;
   logic                   level_q, level_d;
   logic                   pulse_q, pulse_d;
   logic                   stuck_q, stuck_d;

   logic s;
   logic accept;
   logic edge_match;

   // Synchroniser: shift towards the MSB, the MSB is the settled sample.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], in_i};
      s      = sync_q[SYNC_STAGES-1];
   end

   // Debounce: a differing level must be seen on DEBOUNCE_CYC consecutive
   // edges; the last of those edges accepts it.
   always_comb begin
      accept  = (s != level_q) && (dcnt_q == DCNT_LAST);
      dcnt_d  = dcnt_q;
      level_d = level_q;
      if (s == level_q) begin
         dcnt_d = '0;
      end else if (accept) begin
         dcnt_d  = '0;
         level_d = s;
      end else begin
         dcnt_d = dcnt_q + DCNT_W'(1);
      end
   end

   // Event filter: mode is looked at only on the accepting edge, so a mode
   // change can never create or cancel an event from another edge.
   always_comb begin
      if (s == IDLE_LEVEL) begin
         edge_match = (mode_i == MODE_RISE) || (mode_i == MODE_BOTH);
      end else begin
         edge_match = (mode_i == MODE_FALL) || (mode_i == MODE_BOTH);
      end
      pulse_d = accept && edge_match;
   end

   // Stuck detection: count edges spent with the debounced level broken.
   // The accepting edge of a restore clears the flag on that same edge,
   // alongside any restore pulse.
   always_comb begin
      scnt_d  = '0;
      stuck_d = 1'b0;
      if (STUCK_EN && (level_q != IDLE_LEVEL) && !accept) begin
         scnt_d  = (scnt_q == SCNT_SAT) ? scnt_q : scnt_q + SCNT_W'(1);
         stuck_d = (scnt_d == SCNT_SAT);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q  <= {SYNC_STAGES{IDLE_LEVEL}};
         dcnt_q  <= '0;
         scnt_q  <= '0;
         level_q <= IDLE_LEVEL;
         pulse_q <= 1'b0;
         stuck_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         dcnt_q  <= dcnt_d;
         scnt_q  <= scnt_d;
         level_q <= level_d;
         pulse_q <= pulse_d;
         stuck_q <= stuck_d;
      end
   end

   assign pulse_o = pulse_q;
   assign level_o = level_q;
   assign stuck_o = stuck_q;

endmodule : photocell_channel

// File: rtl/photocell_array.sv
// -----------------------------------------------------------------------------
// photocell_array
//
// Multi-channel photocell front-end between the door/counter photocell pins
// and the occupancy counter. Each channel is an independent
// photocell_channel; this level only slices the buses.
//
// Ports:
//   clk  in    : clock, all state on rising edge
//   rst  in    : asynchronous active-high reset
//   bus  slave : photocell_if carrying in / mode / pulse / level / stuck
// -----------------------------------------------------------------------------
module photocell_array
   import photocell_pkg::*;
#(
   parameter int N_CH         = 2,
   parameter int SYNC_STAGES  = 2,
   parameter int DEBOUNCE_CYC = 4,
   parameter int STUCK_CYC    = 1024
) (
   input  logic        clk,
   input  logic        rst,
   photocell_if.slave  bus
);

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      photocell_channel #(
         .SYNC_STAGES  (SYNC_STAGES),
         .DEBOUNCE_CYC (DEBOUNCE_CYC),
         .STUCK_CYC    (STUCK_CYC)
      ) u_ch (
         .clk     (clk),
         .rst     (rst),
         .in_i    (bus.in[i]),
         .mode_i  (bus.mode[2*i +: 2]),
         .pulse_o (bus.pulse[i]),
         .level_o (bus.level[i]),
         .stuck_o (bus.stuck[i])
      );
   end

endmodule : photocell_array

// File: doc/photocell_array.md
# photocell_array

Parametrised, multi-channel photocell front-end for the queue-management datapath. Each channel synchronises a raw beam input, debounces it, and emits a one-cycle event pulse on a per-channel selectable edge (beam broken, beam restored, or both). It also flags a beam held broken too long as stuck. It sits between the door/counter photocell pins and the occupancy counter.

## Interface
- `N_CH`, 2: number of independent photocell channels (≥1).
- `SYNC_STAGES`, 2: synchroniser flops per channel (≥2).
- `DEBOUNCE_CYC`, 4: consecutive cycles a new level must persist before acceptance (≥1).
- `STUCK_CYC`, 1024: cycles of continuous broken beam before `stuck` asserts; 0 disables stuck detection.
- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in` in N_CH: raw photocell levels; 1 = beam intact (idle), 0 = beam broken.
- `mode` in 2·N_CH: per-channel edge select, channel i at bits [2i+1:2i].
- `pulse` out N_CH: one-cycle event strobe per channel.
- `level` out N_CH: debounced line level per channel.
- `stuck` out N_CH: beam broken ≥ STUCK_CYC cycles.

## Operation
- Reset values: synchroniser flops = 1, `level` = all 1, `pulse` = 0, `stuck` = 0, all counters = 0.
- Synchroniser: SYNC_STAGES-deep shift per channel; last stage is `s`.
- Debounce: counter `dcnt`, width clog2(DEBOUNCE_CYC+1).
  - Edge with `s` == `level`: dcnt ← 0.
  - Edge with `s` ≠ `level` and dcnt < DEBOUNCE_CYC−1: dcnt ← dcnt+1.
  - Edge with `s` ≠ `level` and dcnt == DEBOUNCE_CYC−1: `level` ← `s`, dcnt ← 0; transition accepted.
- Mode encodings: 00 OFF (no pulses), 01 RISE (1 on 0→1, beam restored), 10 FALL (1 on 1→0, beam broken), 11 BOTH.
- Pulse: registered; high for exactly the one cycle following the edge on which a transition is accepted and matches `mode`, else 0.
  - `mode` is sampled on that same edge.
  - `mode` changes never generate or cancel pulses for transitions accepted on other edges.
- Stuck: counter `scnt` saturates at STUCK_CYC.
  - `scnt` cleared while `level` = 1; increments on each edge with `level` = 0.
  - `stuck` rises exactly STUCK_CYC edges after the edge on which `level` fell.
  - `stuck` falls on the same edge on which `level` rises.
  - A restored-beam pulse in RISE/BOTH still fires normally on that edge.
- Channels are fully independent; simultaneous events on several channels produce simultaneous pulses.
- Reset mid-debounce or mid-stuck count discards all progress; no pulse is emitted for an interrupted transition. An input still low after reset release debounces from scratch and later yields a FALL event.

## Timing
- Latency: `level` and `pulse` update on the (SYNC_STAGES+DEBOUNCE_CYC)-th rising edge at which the new input value is present, counting the first such edge as 1. Defaults: the 6th edge, i.e. 5 cycles after first sampling.
- Glitch rejection: input excursions shorter than DEBOUNCE_CYC cycles cause no `level` change and no pulse.
- Minimum spacing of accepted transitions per channel is DEBOUNCE_CYC cycles; pulses are never wider than one cycle.
- No handshake; consumers must sample `pulse` every cycle.

## Structure
- Package `photocell_pkg`:
  - mode typedef, 2-bit enum with MODE_OFF, MODE_RISE, MODE_FALL, MODE_BOTH;
  - idle-level constant (1'b1).
- Sub-module `photocell_channel`, one instance per channel via generate. It holds the synchroniser, debounce counter, edge/mode logic and stuck counter, and takes scalar `in`, 2-bit `mode` and the same parameters.
- Top level only slices buses.

## Test plan
- Reset: assert `rst` with `in` = 2'b00 → `level` = 2'b11, `pulse` = 0, `stuck` = 0 while asserted. After release, `level` falls on the 6th edge.
- Clean fall, ch0 mode 11: `in[0]` 1→0 first sampled at edge E → `level[0]` = 0 and `pulse[0]` = 1 for one cycle after edge E+5. Restoring the beam gives an identical rise pulse.
- Glitch, ch0 mode 11: `in[0]` low for 3 cycles → no `level` change, no pulse. Low for exactly 4 cycles → accepted.
- Mode filter: ch1 mode 01 → broken beam gives no pulse, restored beam gives one pulse. Mode 00 → `level` tracks input, `pulse` stays 0.
- Stuck, STUCK_CYC = 16: hold `in[0]` low for 40 cycles → `stuck[0]` rises 16 edges after `level[0]` fell. It clears on the edge where `level[0]` rises.
- Reset mid-operation plus concurrency:
  - assert `rst` when dcnt = 2 → no pulse; low input re-debounces from scratch after release;
  - separately, drive both channels low on the same cycle → both pulses coincide.
